// File: rtl/clb_sched.sv
// clb_sched: round-robin scheduler sharing one CLB-128 ECB core between two requesters.
// Build with CLB_STATS_EN defined to add saturating done/timeout counters.
module clb_sched #(
    parameter int TIMEOUT = 64,
    parameter int DW      = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_mode,
    input  logic [DW-1:0] req0_text,
    input  logic [DW-1:0] req0_key,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_mode,
    input  logic [DW-1:0] req1_text,
    input  logic [DW-1:0] req1_key,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_text,
    output logic          core_rst,
    output logic          core_mode,
    output logic [DW-1:0] core_textin,
    output logic [DW-1:0] core_key,
    input  logic [DW-1:0] core_textout,
    input  logic          core_enable
`ifdef CLB_STATS_EN
    ,
    output logic [15:0]   stat_done,
    output logic [7:0]    stat_err
`endif
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rr;
    logic          r_id;
    logic          r_mode;
    logic [DW-1:0] r_text;
    logic [DW-1:0] r_key;
    logic [7:0]    r_cnt;
    logic          r_rsp_err;
    logic [DW-1:0] r_rsp_text;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_timeout;

    // Ready is gated by reset so no accept pulse can leak out while held in reset.
    assign w_idle    = (r_state == S_IDLE) && rst;
    assign w_gnt0    = w_idle && req0_valid && (!req1_valid || !r_rr);
    assign w_gnt1    = w_idle && req1_valid && (!req0_valid || r_rr);
    assign w_timeout = (r_cnt == LP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_gnt0 || w_gnt1) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN:  if (core_enable || w_timeout) w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_id    <= 1'b0;
            r_mode  <= 1'b0;
            r_text  <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_id   <= w_gnt1;
                r_rr   <= w_gnt0;
                r_mode <= w_gnt1 ? req1_mode : req0_mode;
                r_text <= w_gnt1 ? req1_text : req0_text;
                r_key  <= w_gnt1 ? req1_key  : req0_key;
            end
        end
    end

    // Enable is checked before the timeout so a coincident result is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_text <= '0;
        end else if (r_state == S_LOAD) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 8'd1;
            if (core_enable) begin
                r_rsp_text <= core_textout;
                r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_text <= '0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_id      = r_id;
    assign rsp_err     = r_rsp_err;
    assign rsp_text    = r_rsp_text;
    assign core_rst    = (r_state == S_RUN) || (r_state == S_RESP);
    assign core_mode   = r_mode;
    assign core_textin = r_text;
    assign core_key    = r_key;

`ifdef CLB_STATS_EN
    logic [15:0] r_stat_done;
    logic [7:0]  r_stat_err;
    logic        w_hs;

    assign w_hs = (r_state == S_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_done <= '0;
            r_stat_err  <= '0;
        end else if (w_hs) begin
            if (r_rsp_err) begin
                if (r_stat_err != 8'hFF) r_stat_err <= r_stat_err + 8'd1;
            end else begin
                if (r_stat_done != 16'hFFFF) r_stat_done <= r_stat_done + 16'd1;
            end
        end
    end

    assign stat_done = r_stat_done;
    assign stat_err  = r_stat_err;
`endif

endmodule
